// File: rtl/par2ser_link_if.sv
// Parallel-to-serial link bundle: upstream nibble handshake plus the two-wire serial output.
interface par2ser_link_if;
   logic       en;
   logic [3:0] data;
   logic       ask_for_data;
   logic       scl;
   logic       sda;
   logic       busy;

   modport master (
      input  en, data,
      output ask_for_data, scl, sda, busy
   );

   modport slave (
      output en, data,
      input  ask_for_data, scl, sda, busy
   );
endinterface

// File: rtl/par2ser_link.sv
// Requests a nibble upstream, waits LAT_CYCLES, then sends it MSB first framed by start/stop conditions.
// Optional feature: define PAR2SER_PARITY_EN to append an even-parity bit after the data bits.
module par2ser_link #(
   parameter int unsigned LAT_CYCLES = 2
) (
   input  logic           sclk,
   input  logic           rst,
   par2ser_link_if.master bus
);

`ifdef PAR2SER_PARITY_EN
   localparam int unsigned NBITS = 5;
`else
   localparam int unsigned NBITS = 4;
`endif

   typedef enum logic [3:0] {
      IDLE, REQ, WAIT, LOAD, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, STOP
   } state_t;

   state_t           state_q;
   logic [NBITS-1:0] shreg_q;
   logic [2:0]       idx_q;
   logic [2:0]       cnt_q;
   logic             scl_q;
   logic             sda_q;
   logic             ask_q;
   logic             busy_q;

   logic [NBITS-1:0] load_d;
   logic             last_bit_d;

   // Parity rides along as the LSB of the shift register so it falls out after the data bits.
`ifdef PAR2SER_PARITY_EN
   assign load_d = {bus.data, ^bus.data};
`else
   assign load_d = bus.data;
`endif
   assign last_bit_d = (idx_q == 3'(NBITS - 1));

   // Outputs are assigned together with the state they belong to, so they are valid during that state.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         ask_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ask_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.en) begin
                  state_q <= REQ;
                  ask_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            REQ: begin
               state_q <= WAIT;
               cnt_q   <= 3'(LAT_CYCLES);
            end
            WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_q <= LOAD;
            end
            LOAD: begin
               shreg_q <= load_d;
               idx_q   <= '0;
               sda_q   <= 1'b0;
               state_q <= START;
            end
            START: begin
               scl_q   <= 1'b0;
               sda_q   <= shreg_q[NBITS-1];
               state_q <= BIT_LO;
            end
            BIT_LO: begin
               scl_q   <= 1'b1;
               state_q <= BIT_HI;
            end
            BIT_HI: begin
               scl_q <= 1'b0;
               if (last_bit_d) begin
                  sda_q   <= 1'b0;
                  state_q <= STOP_LO;
               end else begin
                  shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
                  idx_q   <= idx_q + 3'd1;
                  sda_q   <= shreg_q[NBITS-2];
                  state_q <= BIT_LO;
               end
            end
            STOP_LO: begin
               scl_q   <= 1'b1;
               state_q <= STOP_HI;
            end
            STOP_HI: begin
               sda_q   <= 1'b1;
               state_q <= STOP;
            end
            STOP: begin
               if (bus.en) begin
                  ask_q   <= 1'b1;
                  state_q <= REQ;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               scl_q   <= 1'b1;
               sda_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ask_for_data = ask_q;
   assign bus.scl          = scl_q;
   assign bus.sda          = sda_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_par2ser_link.sv
// Randomized and directed bench for par2ser_link against a frame-position reference model.
module tb_par2ser_link;

   localparam int LAT = 2;
`ifdef PAR2SER_PARITY_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int FLEN = LAT + 6 + 2 * NB;

   logic sclk = 1'b0;
   logic rst;
   par2ser_link_if bus ();

   par2ser_link #(.LAT_CYCLES(LAT)) dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 sclk = ~sclk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   logic [3:0] hist [0:4095];

   // Reference model: frame activity, position within frame, captured nibble.
   bit         m_act = 1'b0;
   int         m_pos = 0;
   logic [3:0] m_nib = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   // Expected {scl, sda, ask, busy} for a given position in a frame.
   function automatic logic [3:0] exp_out(input int pos, input logic [3:0] nib);
      int   b;
      int   k;
      logic bitv;
      if (pos == 0) return 4'b1111;
      if (pos <= LAT + 1) return 4'b1101;
      if (pos == LAT + 2) return 4'b1001;
      b = pos - (LAT + 3);
      if (b < 2 * NB) begin
         k    = b / 2;
         bitv = (k < 4) ? nib[3-k] : ^nib;
         return {(b % 2 == 1), bitv, 1'b0, 1'b1};
      end
      b = b - 2 * NB;
      if (b == 0) return 4'b0001;
      if (b == 1) return 4'b1001;
      return 4'b1101;
   endfunction

   function automatic logic [3:0] hget(input int i);
      if (i < 0 || i > 4095) return 4'bxxxx;
      return hist[i];
   endfunction

   task automatic model_step();
      if (rst) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (bus.en) begin
            m_act = 1'b1;
            m_pos = 0;
         end
      end else begin
         if (m_pos == LAT + 1) m_nib = bus.data;
         if (m_pos == FLEN - 1) begin
            if (bus.en) m_pos = 0;
            else m_act = 1'b0;
         end else begin
            m_pos++;
         end
      end
   endtask

   task automatic cycle();
      logic [3:0] e;
      @(posedge sclk);
      model_step();
      #1;
      cyc++;
      if (cyc <= 4095) hist[cyc] = {bus.scl, bus.sda, bus.ask_for_data, bus.busy};
      e = m_act ? exp_out(m_pos, m_nib) : 4'b1100;
      check("scl",  bus.scl,          e[3]);
      check("sda",  bus.sda,          e[2]);
      check("ask",  bus.ask_for_data, e[1]);
      check("busy", bus.busy,         e[0]);
   endtask

   task automatic wait_ask(output int t);
      bit found = 1'b0;
      t = -1000;
      for (int i = 0; i < 64; i++) begin
         cycle();
         if (bus.ask_for_data) begin
            t     = cyc;
            found = 1'b1;
            break;
         end
      end
      check("ask_seen", found, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         t0, tp, t, r;
      int         ask_cnt;
      logic [7:0] sdav, sclv;
      logic [3:0] h;

      rst = 1'b1; bus.en = 1'b0; bus.data = 4'h0;
      repeat (2) cycle();
      rst = 1'b0;
      repeat (10) cycle();

      // Single frame of 1010.
      bus.data = 4'b1010; bus.en = 1'b1;
      wait_ask(t0);
      bus.en = 1'b0;
      repeat (FLEN + 2) cycle();
      for (int k = 0; k < 8; k++) begin
         h = hget(t0 + 5 + k);
         sdav[7-k] = h[2];
         sclv[7-k] = h[3];
      end
      check("frame_sda",  sdav, 8'b11001100);
      check("frame_scl",  sclv, 8'b01010101);
      check("start_cond", hget(t0 + 4), 4'b1001);
      check("stop_hi",    hget(t0 + FLEN - 2), 4'b1001);
      check("stop_cond",  hget(t0 + FLEN - 1), 4'b1101);
      check("idle_after", hget(t0 + FLEN), 4'b1100);

      // Back-to-back frames, upstream increments after each request.
      bus.data = 4'hC; bus.en = 1'b1;
      tp = 0;
      for (int f = 0; f < 20; f++) begin
         wait_ask(t);
         if (f > 0) check("ask_gap", t - tp, FLEN);
         tp = t;
         bus.data = bus.data + 4'h1;
      end
      bus.en = 1'b0;
      repeat (FLEN + 2) cycle();

      // en dropped during BIT_HI of bit 2.
      bus.en = 1'b1; bus.data = 4'($urandom);
      wait_ask(t);
      repeat (LAT + 8) cycle();
      bus.en = 1'b0;
      ask_cnt = 0;
      repeat (FLEN + 8) begin
         cycle();
         ask_cnt += int'(bus.ask_for_data);
      end
      check("ask_after_drop", ask_cnt, 0);
      check("drop_stop", hget(t + FLEN - 1), 4'b1101);
      check("drop_idle", hget(t + FLEN), 4'b1100);

      // Reset during BIT_LO of bit 1.
      bus.en = 1'b1; bus.data = 4'($urandom);
      wait_ask(t);
      repeat (LAT + 5) cycle();
      rst = 1'b1;
      cycle();
      r = cyc;
      check("rst_midframe", {bus.scl, bus.sda, bus.ask_for_data, bus.busy}, 4'b1100);
      rst = 1'b0;
      wait_ask(t);
      check("req_after_rst", t - r, 1);
      bus.en = 1'b0;
      repeat (FLEN + 2) cycle();

`ifdef PAR2SER_PARITY_EN
      bus.data = 4'b0111; bus.en = 1'b1;
      wait_ask(t);
      bus.en = 1'b0;
      repeat (FLEN + 2) cycle();
      h = hget(t + LAT + 11);
      check("par_0111_lo", h[2], 1'b1);
      h = hget(t + LAT + 12);
      check("par_0111_hi", h[2], 1'b1);
      check("par_len", hget(t + 17), 4'b1101);
      bus.data = 4'b0110; bus.en = 1'b1;
      wait_ask(t);
      bus.en = 1'b0;
      repeat (FLEN + 2) cycle();
      h = hget(t + LAT + 11);
      check("par_0110_lo", h[2], 1'b0);
      h = hget(t + LAT + 12);
      check("par_0110_hi", h[2], 1'b0);
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         bus.en   = ($urandom_range(0, 3) != 0);
         bus.data = 4'($urandom);
         cycle();
      end
      rst = 1'b0; bus.en = 1'b0;
      repeat (FLEN + 2) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/par2ser_link.md
PAR2SER_LINK -- requirements
Module: par2ser_link

Interface
REQ-001 Parameter LAT_CYCLES, default 2, number of sclk cycles waited after the ask_for_data pulse before data is sampled (legal range 1..7).
REQ-002 Port sclk  input  1  system clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port en  input  1  frame enable; level-sensitive, sampled at frame boundaries only.
REQ-005 Port data  input  4  parallel nibble from upstream generator.
REQ-006 Port ask_for_data  output  1  one-cycle request pulse to upstream for the next nibble.
REQ-007 Port scl  output  1  serial clock line.
REQ-008 Port sda  output  1  serial data line.
REQ-009 Port busy  output  1  high from REQ through STOP inclusive.

Function
REQ-010 FSM states SHALL be: IDLE, REQ, WAIT, LOAD, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI, STOP; all outputs registered.
REQ-011 IDLE: scl=1, sda=1, ask_for_data=0, busy=0; leave to REQ on the first cycle en=1.
REQ-012 REQ lasts exactly 1 cycle with ask_for_data=1, scl=1, sda=1; then WAIT.
REQ-013 WAIT lasts exactly LAT_CYCLES cycles (3-bit down-counter), scl=1, sda=1; then LOAD.
REQ-014 LOAD, 1 cycle: data captured into a 4-bit shift register, bit index cleared; scl=1, sda=1.
REQ-015 START, 1 cycle: scl=1, sda=0 (start condition = sda falling while scl high).
REQ-016 Bits shifted MSB first; each bit is BIT_LO (scl=0, sda=bit) then BIT_HI (scl=1, sda=bit); sda never changes while scl=1 within a bit.
REQ-017 After the last bit's BIT_HI: STOP_LO (scl=0, sda=0), STOP_HI (scl=1, sda=0), STOP (scl=1, sda=1 = stop condition).
REQ-018 From STOP: en=1 -> REQ next cycle (back-to-back frames); en=0 -> IDLE.
REQ-019 Frame length REQ..STOP inclusive = 14+LAT_CYCLES cycles (16 at default) without parity.
REQ-020 en deasserted mid-frame SHALL NOT abort; the frame completes, then IDLE.
REQ-021 Changes on data outside the LOAD sampling edge SHALL NOT affect the frame in progress.
REQ-022 ask_for_data SHALL never be high for more than 1 consecutive cycle.

Reset
REQ-023 rst=1 at a rising edge forces IDLE, scl=1, sda=1, ask_for_data=0, busy=0, shift register, bit index and WAIT counter to 0, regardless of state.
REQ-024 Reset mid-frame SHALL abandon the frame without a stop condition; the first frame after rst falls starts with REQ.

Configuration
REQ-025 Macro PAR2SER_PARITY_EN: when defined, one extra BIT_LO/BIT_HI pair carrying even parity (XOR of the 4 captured bits) is inserted after the last data bit; frame = 16+LAT_CYCLES cycles.
REQ-026 Without PAR2SER_PARITY_EN: no parity logic; exactly 4 bit pairs per frame.

Verification
REQ-027 rst high 2 cycles, en=0 -> scl=1, sda=1, ask_for_data=0, busy=0 held for 10 cycles.
REQ-028 en=1, data=4'b1010, LAT=2 -> ask pulse at t0, start at t4, sda over t5..t12 = 1,1,0,0,1,1,0,0 with scl = 0,1 alternating, stop condition at t15.
REQ-029 en held 1, upstream increments data after each ask -> consecutive frames carry n, n+1, ... with ask pulses exactly 16 cycles apart, wrapping 4'hF -> 4'h0.
REQ-030 en dropped during BIT_HI of bit 2 -> frame completes with stop, then IDLE; no further ask_for_data.
REQ-031 rst asserted during BIT_LO of bit 1 -> next cycle scl=1, sda=1, busy=0; after rst falls with en=1, a new REQ pulse occurs.
REQ-032 PAR2SER_PARITY_EN defined, data=4'b0111 -> fifth bit pair sda=1; data=4'b0110 -> sda=0; frame 18 cycles.
